sym_operand_loader: RTL and testbench
=====================================

# sym_operand_loader

Upstream feeder for the `sym` lane-arithmetic stage. Accepts a byte stream over a valid/ready handshake and packs each group of 16 bytes into the four 32-bit operand words A, B, C and I (4 × 8-bit lanes each). It presents each complete set to `sym` through a registered valid/ready output slot. A single assembly buffer lets the next set fill while the current set is held.

## Interface
Parameters:
- `CNT_W`, 16: width of the delivered-set counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_data`  in  8  operand byte.
- `in_sof`  in  1  marks the first byte of a set; qualified by `in_valid`.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `A`, `B`, `C`, `I`  out  32 each  operand words to `sym`; stable while `op_valid`=1.
- `op_valid`  out  1  output set valid.
- `op_ready`  in  1  consumer takes the set this cycle.
- `frame_err`  out  1  one-cycle pulse: set restarted by `in_sof` mid-set.
- `mask_err`  out  1  sticky; an I byte greater than 1 was accepted. Cleared only by `rst`.
- `sets_out`  out  `CNT_W`  count of sets handed off; wraps modulo 2^`CNT_W`.

## Operation
- **Transfer:** a byte transfers when `in_valid && in_ready`. A set transfers when `op_valid && op_ready`.
- **Byte order:** the byte index k runs 0..15. k=0..3 → A, 4..7 → B, 8..11 → C, 12..15 → I.
- **Lane order:** within each word the first byte is lane 3, bits [31:24], and the last byte is lane 0, bits [7:0].
  - Example: bytes 01,01,03,04 give A=0x01010304.
- **FILL state:**
  - `in_ready`=1.
  - The byte counter increments on each accepted byte.
  - An accepted byte with `in_sof`=1 is always stored as k=0 and sets the counter to 1.
  - If the counter was nonzero at that point, pulse `frame_err` for one cycle and discard the partial set.
- **`in_sof` outside k=0:** `in_sof`=0 on byte k=0 is accepted; `in_sof` is required only to resynchronise.
- **Completion on byte 15:**
  - If the output slot is free or being consumed this cycle (`!op_valid || op_ready`), load A/B/C/I directly into the output registers. The counter returns to 0 and the state stays FILL.
  - Otherwise go to HOLD.
- **HOLD state:**
  - `in_ready`=0.
  - The complete set waits in the assembly buffer.
  - On the first cycle with `!op_valid || op_ready`, move the set to the output and return to FILL with counter 0.
- **Output slot:**
  - `op_valid` sets on load.
  - `op_valid` clears on set transfer unless a new load happens in the same cycle; in that case it stays 1 and the words update.
  - A/B/C/I never change while `op_valid`=1 and `op_ready`=0.
- **`sets_out`:** increments by 1 on every set transfer.
- **`mask_err`:** sets when a byte with k=12..15 and value > 8'd1 is accepted. The byte is still stored unmodified.

## Timing
- Reset values:
  - A, B, C, I = 0.
  - `op_valid`=0, `frame_err`=0, `mask_err`=0, `sets_out`=0.
  - State FILL, counter 0, so `in_ready`=1 on the first cycle after reset.
- **Latency:** if byte 15 is accepted at edge t and the slot is free, `op_valid`=1 and the new words are visible from edge t+1.
- **Throughput:**
  - One byte per cycle.
  - Sets back-to-back every 16 cycles when `op_ready` is held 1.
  - No bubble between sets.
- **Outputs:** all are registered. `in_ready` depends on state only, not combinationally on `op_ready`.
- **`frame_err`:** high exactly the cycle after the offending accept.
- **Reset mid-set or in HOLD:** the partial or held set is dropped and outputs return to reset values on the next edge.
- **Reset with `op_valid`=1:** `op_valid` drops even if the set was not consumed, and `sets_out` does not count it.

## Test plan
1. **Single set:** after reset, send 16 bytes 01,01,03,04, 05,06,02,01, 02,01,02,04, 01,00,00,01 with `in_sof` on the first byte and `op_ready`=1.
   - Required: A=0x01010304, B=0x05060201, C=0x02010204, I=0x01000001.
   - `op_valid` rises 1 cycle after byte 15, `sets_out`=1, `mask_err`=0.
2. **Backpressure:** hold `op_ready`=0 and send two full sets.
   - After the second set completes, `in_ready`=0 and the first set's words remain stable.
   - Raise `op_ready` for one cycle: the second set appears next cycle and `in_ready` returns to 1.
   - `sets_out`=1 after that single-cycle `op_ready` pulse; raising `op_ready` again so the second set is taken gives `sets_out`=2.
3. **Resync:** send 5 bytes, then a byte with `in_sof`=1 followed by 15 more.
   - Required: one `frame_err` pulse; the output set is built only from the last 16 bytes.
4. **Mask check:** a set with I bytes 00,02,00,01.
   - Required: `mask_err` goes to 1 and stays set.
   - I=0x00020001.
   - Clears only after `rst`.
5. **Streaming:** 4 sets back-to-back with `in_valid` and `op_ready` held 1.
   - Required: `op_valid` pulses at 16-cycle spacing, `in_ready` never deasserts, `sets_out`=4.
6. **Reset mid-operation:** assert `rst` at byte 9 and separately while in HOLD.
   - Required: all outputs at reset values next cycle, and the next full set is delivered correctly.

Source files
------------

// File: rtl/sym_operand_loader.sv
// Byte-stream front end for the sym lane-arithmetic stage: packs 16 bytes into
// the A/B/C/I operand words and presents each set through a registered valid/ready slot.
module sym_operand_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [31:0]      C,
  output logic [31:0]      I,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             frame_err,
  output logic             mask_err,
  output logic [CNT_W-1:0] sets_out
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SET_W  = 4 * WORD_W;
  localparam int unsigned POS_W  = IDX_W + 3;

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [SET_W-1:0]   r_buf;
  logic [WORD_W-1:0]  r_a, r_b, r_c, r_i;
  logic               r_op_valid;
  logic               r_in_ready;
  logic               r_frame_err;
  logic               r_mask_err;
  logic [CNT_W-1:0]   r_sets;

  logic               w_accept;
  logic               w_slot_free;
  logic [IDX_W-1:0]   w_k;
  logic               w_last;
  logic               w_mask_hit;
  logic [POS_W-1:0]   w_pos;
  logic [SET_W-1:0]   w_set;

  assign w_accept    = in_valid && r_in_ready;
  assign w_slot_free = !r_op_valid || op_ready;
  // A start-of-set byte always lands in slot 0, whatever the counter says.
  assign w_k         = in_sof ? '0 : r_cnt;
  assign w_last      = (w_k == IDX_W'(15));
  assign w_mask_hit  = (w_k[IDX_W-1 -: 2] == 2'b11) && (in_data > 8'd1);
  // Byte k sits at bit offset (15-k)*8, so byte 0 is A[31:24] and byte 15 is I[7:0].
  assign w_pos       = {~w_k, 3'b000};

  always_comb begin
    w_set = r_buf;
    w_set[w_pos +: BYTE_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_i         <= '0;
      r_op_valid  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_frame_err <= 1'b0;
      r_mask_err  <= 1'b0;
      r_sets      <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_op_valid && op_ready) begin
        r_op_valid <= 1'b0;
        r_sets     <= r_sets + CNT_W'(1);
      end
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf <= w_set;
            r_cnt <= w_last ? '0 : w_k + IDX_W'(1);
            if (in_sof && (r_cnt != '0)) r_frame_err <= 1'b1;
            if (w_mask_hit) r_mask_err <= 1'b1;
            if (w_last) begin
              if (w_slot_free) begin
                {r_a, r_b, r_c, r_i} <= w_set;
                r_op_valid           <= 1'b1;
              end else begin
                r_state    <= S_HOLD;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          // Completed set parked in r_buf until the output slot opens.
          if (w_slot_free) begin
            {r_a, r_b, r_c, r_i} <= r_buf;
            r_op_valid           <= 1'b1;
            r_state              <= S_FILL;
            r_in_ready           <= 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign A         = r_a;
  assign B         = r_b;
  assign C         = r_c;
  assign I         = r_i;
  assign op_valid  = r_op_valid;
  assign frame_err = r_frame_err;
  assign mask_err  = r_mask_err;
  assign sets_out  = r_sets;

endmodule

// File: tb/tb_sym_operand_loader.sv
// Bench for sym_operand_loader: scenario tasks plus a transaction-level byte/set model.
module tb_sym_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A, B, C, I;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        frame_err;
  logic        mask_err;
  logic [15:0] sets_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (written only by the monitor)
  logic [7:0]   cur[$];
  logic [127:0] pend[$];
  logic [127:0] exp_done[$];
  logic [127:0] obs_done[$];
  logic [127:0] assembled;
  logic [127:0] held_words;
  logic         prev_hold = 1'b0;
  logic         exp_mask = 1'b0;
  logic [15:0]  exp_xfers = '0;
  int           exp_ferr = 0;
  int           obs_ferr = 0;
  int           stab_viol = 0;

  int rd_idx = 0;

  sym_operand_loader #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .A(A), .B(B), .C(C), .I(I), .op_valid(op_valid),
    .op_ready(op_ready), .frame_err(frame_err), .mask_err(mask_err), .sets_out(sets_out)
  );

  always #5 clk = ~clk;

  // Monitor: sees the handshakes that the coming rising edge will act on.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cur.delete();
        pend.delete();
        exp_mask  = 1'b0;
        exp_xfers = '0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && (({A, B, C, I} !== held_words) || !op_valid)) stab_viol++;
        prev_hold  = op_valid && !op_ready;
        held_words = {A, B, C, I};
        if (frame_err) obs_ferr++;
        if (op_valid && op_ready) begin
          obs_done.push_back({A, B, C, I});
          if (pend.size() > 0) exp_done.push_back(pend.pop_front());
          else exp_done.push_back('x);
          exp_xfers = exp_xfers + 16'd1;
        end
        if (in_valid && in_ready) begin
          if (in_sof) begin
            if (cur.size() != 0) exp_ferr++;
            cur.delete();
          end
          if (cur.size() >= 12 && in_data > 8'd1) exp_mask = 1'b1;
          cur.push_back(in_data);
          if (cur.size() == 16) begin
            assembled = '0;
            foreach (cur[j]) assembled = {assembled[119:0], cur[j]};
            pend.push_back(assembled);
            cur.delete();
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] rand_set();
    logic [127:0] s;
    s[127:32] = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 4; j++) s[8*j +: 8] = 8'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic sof);
    int waited;
    waited = 0;
    in_data = b; in_sof = sof; in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_set(input logic [127:0] s);
    for (int k = 0; k < 16; k++) send_byte(s[8*(15-k) +: 8], k == 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({A, B, C, I} !== 128'd0) begin n_err++; $display("FAIL reset_words got=%h want=0", {A, B, C, I}); end
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL reset_op_valid got=%b want=0", op_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    n_vec++; if (mask_err !== 1'b0) begin n_err++; $display("FAIL reset_mask_err got=%b want=0", mask_err); end
    n_vec++; if (sets_out !== 16'd0) begin n_err++; $display("FAIL reset_sets_out got=%0d want=0", sets_out); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    op_ready = 1'b1;
    send_set(128'h01010304_05060201_02010204_01000001);
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got=%b want=1", op_valid); end
    n_vec++; if (A !== 32'h01010304) begin n_err++; $display("FAIL single_A got=%h want=01010304", A); end
    n_vec++; if (B !== 32'h05060201) begin n_err++; $display("FAIL single_B got=%h want=05060201", B); end
    n_vec++; if (C !== 32'h02010204) begin n_err++; $display("FAIL single_C got=%h want=02010204", C); end
    n_vec++; if (I !== 32'h01000001) begin n_err++; $display("FAIL single_I got=%h want=01000001", I); end
    @(posedge clk); #1;
    n_vec++; if (sets_out !== 16'd1) begin n_err++; $display("FAIL single_sets_out got=%0d want=1", sets_out); end
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b want=0", op_valid); end
    n_vec++; if (mask_err !== 1'b0) begin n_err++; $display("FAIL single_mask_err got=%b want=0", mask_err); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL single_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s1, s2;
    s1 = rand_set(); s2 = rand_set();
    do_reset();
    op_ready = 1'b0;
    send_set(s1);
    send_set(s2);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready got=%b want=0", in_ready); end
    n_vec++; if ({A, B, C, I} !== s1) begin n_err++; $display("FAIL bp_first_words got=%h want=%h", {A, B, C, I}, s1); end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++; if ({A, B, C, I} !== s1 || op_valid !== 1'b1) begin n_err++; $display("FAIL bp_stable got=%h want=%h", {A, B, C, I}, s1); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_hold got=%b want=0", in_ready); end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    n_vec++; if ({A, B, C, I} !== s2) begin n_err++; $display("FAIL bp_second_words got=%h want=%h", {A, B, C, I}, s2); end
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid got=%b want=1", op_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b want=1", in_ready); end
    n_vec++; if (sets_out !== 16'd1) begin n_err++; $display("FAIL bp_count1 got=%0d want=1", sets_out); end
    repeat (2) begin @(posedge clk); #1; end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    n_vec++; if (sets_out !== 16'd2) begin n_err++; $display("FAIL bp_count2 got=%0d want=2", sets_out); end
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b want=0", op_valid); end
    n_vec++; if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stability got=%0d want=0", stab_viol); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL bp_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
  endtask

  task automatic test_resync();
    logic [127:0] s;
    int base_f;
    s = rand_set();
    do_reset();
    op_ready = 1'b1;
    base_f = obs_ferr;
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), k == 0);
    send_byte(s[127:120], 1'b1);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL resync_pulse got=%b want=1", frame_err); end
    for (int k = 1; k < 16; k++) send_byte(s[8*(15-k) +: 8], 1'b0);
    n_vec++; if ({A, B, C, I} !== s || op_valid !== 1'b1) begin n_err++; $display("FAIL resync_words got=%h want=%h", {A, B, C, I}, s); end
    @(posedge clk); #1;
    n_vec++; if (obs_ferr - base_f !== 1) begin n_err++; $display("FAIL resync_pulse_count got=%0d want=1", obs_ferr - base_f); end
    n_vec++; if (sets_out !== 16'd1) begin n_err++; $display("FAIL resync_sets_out got=%0d want=1", sets_out); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL resync_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
  endtask

  task automatic test_mask();
    logic [127:0] s;
    s = rand_set();
    s[31:0] = 32'h00020001;
    do_reset();
    op_ready = 1'b1;
    send_set(s);
    n_vec++; if (mask_err !== 1'b1) begin n_err++; $display("FAIL mask_set got=%b want=1", mask_err); end
    n_vec++; if (I !== 32'h00020001) begin n_err++; $display("FAIL mask_I got=%h want=00020001", I); end
    send_set(rand_set());
    @(posedge clk); #1;
    n_vec++; if (mask_err !== 1'b1 || mask_err !== exp_mask) begin n_err++; $display("FAIL mask_sticky got=%b want=1", mask_err); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL mask_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
    do_reset();
    n_vec++; if (mask_err !== 1'b0) begin n_err++; $display("FAIL mask_clear got=%b want=0", mask_err); end
  endtask

  task automatic test_stream();
    logic [127:0] sets [4];
    int rdy_bad, ov_bad;
    rdy_bad = 0; ov_bad = 0;
    for (int n = 0; n < 4; n++) sets[n] = rand_set();
    do_reset();
    op_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_sof   = (i % 16) == 0;
      in_data  = sets[i/16][8*(15-(i%16)) +: 8];
      @(posedge clk); #1;
      if (in_ready !== 1'b1) rdy_bad++;
      if (op_valid !== ((i % 16) == 15)) ov_bad++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    n_vec++; if (rdy_bad !== 0) begin n_err++; $display("FAIL stream_in_ready got=%0d_low_cycles want=0", rdy_bad); end
    n_vec++; if (ov_bad !== 0) begin n_err++; $display("FAIL stream_spacing got=%0d_bad_cycles want=0", ov_bad); end
    @(posedge clk); #1;
    n_vec++; if (sets_out !== 16'd4 || sets_out !== exp_xfers) begin n_err++; $display("FAIL stream_sets_out got=%0d want=4", sets_out); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL stream_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s1, s2, s3;
    s1 = rand_set(); s2 = rand_set(); s3 = rand_set();
    do_reset();
    op_ready = 1'b0;
    send_set(s1);
    for (int k = 0; k < 9; k++) send_byte(s2[8*(15-k) +: 8], k == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if ({A, B, C, I} !== 128'd0 || op_valid !== 1'b0) begin n_err++; $display("FAIL midset_outputs got=%h/%b want=0/0", {A, B, C, I}, op_valid); end
    n_vec++; if (sets_out !== 16'd0 || in_ready !== 1'b1 || frame_err !== 1'b0) begin n_err++; $display("FAIL midset_ctrl got=%0d/%b/%b want=0/1/0", sets_out, in_ready, frame_err); end
    op_ready = 1'b1;
    send_set(s3);
    n_vec++; if ({A, B, C, I} !== s3) begin n_err++; $display("FAIL midset_recover got=%h want=%h", {A, B, C, I}, s3); end
    @(posedge clk); #1;
    n_vec++; if (sets_out !== 16'd1) begin n_err++; $display("FAIL midset_count got=%0d want=1", sets_out); end

    op_ready = 1'b0;
    send_set(rand_set());
    send_set(rand_set());
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_entered got=%b want=0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if ({A, B, C, I} !== 128'd0 || op_valid !== 1'b0) begin n_err++; $display("FAIL hold_outputs got=%h/%b want=0/0", {A, B, C, I}, op_valid); end
    n_vec++; if (in_ready !== 1'b1 || sets_out !== 16'd0) begin n_err++; $display("FAIL hold_ctrl got=%b/%0d want=1/0", in_ready, sets_out); end
    s1 = rand_set();
    op_ready = 1'b1;
    send_set(s1);
    n_vec++; if ({A, B, C, I} !== s1 || op_valid !== 1'b1) begin n_err++; $display("FAIL hold_recover got=%h want=%h", {A, B, C, I}, s1); end
    @(posedge clk); #1;
    n_vec++; if (sets_out !== 16'd1) begin n_err++; $display("FAIL hold_count got=%0d want=1", sets_out); end
    while (rd_idx < obs_done.size()) begin
      n_vec++; if (obs_done[rd_idx] !== exp_done[rd_idx]) begin n_err++; $display("FAIL rstmid_set[%0d] got=%h want=%h", rd_idx, obs_done[rd_idx], exp_done[rd_idx]); end
      rd_idx++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_resync();
    test_mask();
    test_stream();
    test_reset_mid();
    n_vec++; if (exp_ferr !== 1) begin n_err++; $display("FAIL model_frame_errs got=%0d want=1", exp_ferr); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
